// File: rtl/iq_frame_sched_if.sv
// Upstream IQ beat channel: valid/ready handshake carrying two IQ samples per beat
// plus an end-of-frame marker.
interface iq_frame_sched_if #(
  parameter int BW = 16
);
  logic              s_vld;
  logic              s_rdy;
  logic [3:0][BW-1:0] s_data;
  logic              s_last;

  modport master (output s_vld, output s_data, output s_last, input s_rdy);
  modport slave  (input s_vld, input s_data, input s_last, output s_rdy);
endinterface

// File: rtl/iq_frame_sched.sv
// Frame admission controller for the IQ network front end: exact-length frames,
// in-flight frame cap driven by result pulses, and a forced idle gap between frames.
module iq_frame_sched #(
  parameter int BW            = 16,
  parameter int L2_IMG        = 10,
  parameter int MAX_INFLIGHT  = 2,
  parameter int GAP_CYC       = 16,
  parameter int OUT_PER_FRAME = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  iq_frame_sched_if.slave                    up,
  output logic                               net_vld,
  output logic [3:0][BW-1:0]                 net_data,
  input  logic                               net_out_vld,
  output logic                               frame_start,
  output logic                               frame_done,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight,
  output logic                               err_len,
  output logic                               err_spur
);
  localparam int FRAME_BEATS = 2 ** (L2_IMG - 1);
  localparam int BCW = (L2_IMG > 1) ? L2_IMG - 1 : 1;
  localparam int GCW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int OCW = (OUT_PER_FRAME > 1) ? $clog2(OUT_PER_FRAME) : 1;
  localparam int IW  = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

  state_t             state_q;
  logic [BCW-1:0]     beat_cnt_q;
  logic [GCW-1:0]     gap_cnt_q;
  logic [OCW-1:0]     out_cnt_q;
  logic [IW-1:0]      inflight_q, inflight_d;
  logic               net_vld_q, frame_start_q, frame_done_q, err_len_q, err_spur_q;
  logic [3:0][BW-1:0] net_data_q;
  logic               s_rdy, accept, admit, final_beat, out_wrap, spur, gap_end;

  always_comb begin
    s_rdy = 1'b0;
    case (state_q)
      IDLE:    s_rdy = (inflight_q < IW'(MAX_INFLIGHT));
      STREAM:  s_rdy = 1'b1;
      default: s_rdy = 1'b0;
    endcase
  end

  assign up.s_rdy   = s_rdy;
  assign accept     = up.s_vld & s_rdy;
  assign admit      = accept & (state_q == IDLE);
  assign final_beat = (FRAME_BEATS == 1) ||
                      ((state_q == STREAM) && (beat_cnt_q == BCW'(FRAME_BEATS - 1)));
  assign gap_end    = (gap_cnt_q == GCW'(GAP_CYC - 1));
  // A result pulse with nothing in flight is an error and must not disturb the counters.
  assign spur       = net_out_vld & (inflight_q == '0);
  assign out_wrap   = net_out_vld & ~spur & (out_cnt_q == OCW'(OUT_PER_FRAME - 1));

  always_comb begin
    inflight_d = inflight_q;
    if (admit && !out_wrap)
      inflight_d = inflight_q + 1'b1;
    else if (!admit && out_wrap)
      inflight_d = inflight_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      beat_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      out_cnt_q     <= '0;
      inflight_q    <= '0;
      net_vld_q     <= 1'b0;
      net_data_q    <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      err_len_q     <= 1'b0;
      err_spur_q    <= 1'b0;
    end else begin
      net_vld_q     <= accept;
      frame_start_q <= admit;
      frame_done_q  <= out_wrap;
      inflight_q    <= inflight_d;
      if (accept)
        net_data_q <= up.s_data;
      // Frame length is authoritative; s_last is only cross-checked against it.
      if (accept && (up.s_last != final_beat))
        err_len_q <= 1'b1;
      if (spur)
        err_spur_q <= 1'b1;
      if (net_out_vld && !spur)
        out_cnt_q <= out_wrap ? '0 : out_cnt_q + 1'b1;

      case (state_q)
        IDLE: begin
          if (accept) begin
            if (FRAME_BEATS == 1) begin
              state_q <= (GAP_CYC > 0) ? GAP : IDLE;
            end else begin
              state_q    <= STREAM;
              beat_cnt_q <= BCW'(1);
            end
          end
        end
        STREAM: begin
          if (accept) begin
            if (final_beat) begin
              beat_cnt_q <= '0;
              state_q    <= (GAP_CYC > 0) ? GAP : IDLE;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_end) begin
            gap_cnt_q <= '0;
            state_q   <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign net_vld     = net_vld_q;
  assign net_data    = net_data_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign inflight    = inflight_q;
  assign err_len     = err_len_q;
  assign err_spur    = err_spur_q;
endmodule

// File: tb/tb_iq_frame_sched.sv
// Bench for iq_frame_sched: two instances (single-result and three-result frames)
// checked every cycle against a frame-level reference model.
module tb_iq_frame_sched;
  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  iq_frame_sched_if #(.BW(16)) ifa ();
  iq_frame_sched_if #(.BW(16)) ifb ();

  logic             net_vld_a, net_vld_b, ova, ovb;
  logic             fs_a, fs_b, fd_a, fd_b, el_a, el_b, es_a, es_b;
  logic [3:0][15:0] nd_a, nd_b;
  logic [1:0]       inf_a, inf_b;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // A: 4-beat frames, 2-cycle gap, one result per frame.
  iq_frame_sched #(.BW(16), .L2_IMG(3), .MAX_INFLIGHT(2), .GAP_CYC(2), .OUT_PER_FRAME(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .up(ifa), .net_vld(net_vld_a), .net_data(nd_a),
    .net_out_vld(ova), .frame_start(fs_a), .frame_done(fd_a), .inflight(inf_a),
    .err_len(el_a), .err_spur(es_a));

  // B: 4-beat frames, no gap, three results per frame.
  iq_frame_sched #(.BW(16), .L2_IMG(3), .MAX_INFLIGHT(2), .GAP_CYC(0), .OUT_PER_FRAME(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .up(ifb), .net_vld(net_vld_b), .net_data(nd_b),
    .net_out_vld(ovb), .frame_start(fs_b), .frame_done(fd_b), .inflight(inf_b),
    .err_len(el_b), .err_spur(es_b));

  // Reference model: pos = beats already taken in the open frame, gap_left = idle cycles still owed.
  typedef struct packed {
    int          pos;
    int          gap_left;
    int          infl;
    int          outs;
    bit          vld;
    logic [63:0] data;
    bit          fs;
    bit          fd;
    bit          el;
    bit          es;
  } mstate_t;

  mstate_t ma, mb;

  function automatic bit m_rdy(mstate_t s, int maxf);
    if (s.gap_left > 0) return 1'b0;
    if (s.pos > 0) return 1'b1;
    return s.infl < maxf;
  endfunction

  function automatic mstate_t m_step(mstate_t s, bit v, logic [63:0] d, bit l, bit o,
                                     int nbeats, int gap, int maxf, int opf);
    mstate_t n;
    bit acc, fin;
    n = s;
    n.vld = 1'b0;
    n.fs = 1'b0;
    n.fd = 1'b0;
    acc = v && m_rdy(s, maxf);
    if (s.gap_left > 0) n.gap_left = s.gap_left - 1;
    if (acc) begin
      n.vld = 1'b1;
      n.data = d;
      fin = (s.pos == nbeats - 1);
      if (l != fin) n.el = 1'b1;
      if (s.pos == 0) begin
        n.fs = 1'b1;
        n.infl = n.infl + 1;
      end
      n.pos = fin ? 0 : s.pos + 1;
      if (fin) n.gap_left = gap;
    end
    if (o) begin
      if (s.infl == 0) n.es = 1'b1;
      else if (s.outs == opf - 1) begin
        n.outs = 0;
        n.infl = n.infl - 1;
        n.fd = 1'b1;
      end else n.outs = s.outs + 1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '0;
      mb <= '0;
    end else begin
      ma <= m_step(ma, ifa.s_vld, ifa.s_data, ifa.s_last, ova, 4, 2, 2, 1);
      mb <= m_step(mb, ifb.s_vld, ifb.s_data, ifb.s_last, ovb, 4, 0, 2, 3);
    end
  end

  function automatic logic [71:0] obs_a();
    return {ifa.s_rdy, net_vld_a, nd_a, fs_a, fd_a, inf_a, el_a, es_a};
  endfunction
  function automatic logic [71:0] exp_a();
    return {m_rdy(ma, 2), ma.vld, ma.data, ma.fs, ma.fd, ma.infl[1:0], ma.el, ma.es};
  endfunction
  function automatic logic [71:0] obs_b();
    return {ifb.s_rdy, net_vld_b, nd_b, fs_b, fd_b, inf_b, el_b, es_b};
  endfunction
  function automatic logic [71:0] exp_b();
    return {m_rdy(mb, 2), mb.vld, mb.data, mb.fs, mb.fd, mb.infl[1:0], mb.el, mb.es};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic drv_a(bit v, logic [63:0] d, bit l, bit o);
    ifa.s_vld = v; ifa.s_data = d; ifa.s_last = l; ova = o;
  endtask
  task automatic drv_b(bit v, logic [63:0] d, bit l, bit o);
    ifb.s_vld = v; ifb.s_data = d; ifb.s_last = l; ovb = o;
  endtask

  task automatic drain_a();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (obs_a() !== exp_a()) begin
        errors++; $display("FAIL drain_a c=%0d got=%h exp=%h", c, obs_a(), exp_a());
      end
      drv_a(1'b0, rnd64(), 1'b0, ma.infl > 0);
    end
  endtask

  task automatic test_reset();
    logic [71:0] rv;
    rv = {1'b1, 71'b0};
    rst_n = 1'b0;
    drv_a(1'b0, 64'd0, 1'b0, 1'b0);
    drv_b(1'b0, 64'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (obs_a() !== rv) begin errors++; $display("FAIL reset_a got=%h exp=%h", obs_a(), rv); end
    checks++;
    if (obs_b() !== rv) begin errors++; $display("FAIL reset_b got=%h exp=%h", obs_b(), rv); end
    rst_n = 1'b1;
    $display("test_reset: done");
  endtask

  task automatic test_basic_frame();
    int sent = 0, seen = 0, low = 0;
    bit rose = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (obs_a() !== exp_a()) begin
        errors++; $display("FAIL basic c=%0d got=%h exp=%h", c, obs_a(), exp_a());
      end
      if (net_vld_a) seen++;
      if (sent == 4 && !rose) begin
        if (ifa.s_rdy) rose = 1; else low++;
      end
      if (sent < 4) begin
        drv_a(1'b1, rnd64(), sent == 3, 1'b0);
        if (m_rdy(ma, 2)) sent++;
      end else drv_a(1'b0, rnd64(), 1'b0, 1'b0);
    end
    checks++;
    if (seen !== 4) begin errors++; $display("FAIL basic_beats got=%0d exp=4", seen); end
    checks++;
    if (low !== 2) begin errors++; $display("FAIL basic_gap got=%0d exp=2", low); end
    checks++;
    if (el_a !== 1'b0) begin errors++; $display("FAIL basic_err_len got=%b exp=0", el_a); end
    $display("test_basic_frame: beats=%0d gap=%0d", seen, low);
  endtask

  task automatic test_inflight_cap();
    int sent = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (obs_a() !== exp_a()) begin
        errors++; $display("FAIL cap c=%0d got=%h exp=%h", c, obs_a(), exp_a());
      end
      if (sent < 4) begin
        drv_a(1'b1, rnd64(), sent == 3, 1'b0);
        if (m_rdy(ma, 2)) sent++;
      end else drv_a(1'b1, rnd64(), 1'b0, 1'b0);
    end
    checks++;
    if (inf_a !== 2'd2) begin errors++; $display("FAIL cap_inflight got=%0d exp=2", inf_a); end
    checks++;
    if (ifa.s_rdy !== 1'b0) begin errors++; $display("FAIL cap_rdy got=%b exp=0", ifa.s_rdy); end
    @(negedge clk);
    drv_a(1'b0, rnd64(), 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (obs_a() !== exp_a()) begin errors++; $display("FAIL cap_release got=%h exp=%h", obs_a(), exp_a()); end
    checks++;
    if (fd_a !== 1'b1 || inf_a !== 2'd1 || ifa.s_rdy !== 1'b1) begin
      errors++; $display("FAIL cap_done got fd=%b inf=%0d rdy=%b exp fd=1 inf=1 rdy=1", fd_a, inf_a, ifa.s_rdy);
    end
    drv_a(1'b0, rnd64(), 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (obs_a() !== exp_a()) begin errors++; $display("FAIL cap_after got=%h exp=%h", obs_a(), exp_a()); end
    $display("test_inflight_cap: done");
  endtask

  task automatic test_simul();
    int sent = 1;
    @(negedge clk);
    drv_a(1'b1, rnd64(), 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (obs_a() !== exp_a()) begin errors++; $display("FAIL simul got=%h exp=%h", obs_a(), exp_a()); end
    checks++;
    if (fs_a !== 1'b1 || fd_a !== 1'b1 || inf_a !== 2'd1) begin
      errors++; $display("FAIL simul_pulses got fs=%b fd=%b inf=%0d exp fs=1 fd=1 inf=1", fs_a, fd_a, inf_a);
    end
    drv_a(1'b1, rnd64(), 1'b0, 1'b0);
    if (m_rdy(ma, 2)) sent++;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (obs_a() !== exp_a()) begin
        errors++; $display("FAIL simul_tail c=%0d got=%h exp=%h", c, obs_a(), exp_a());
      end
      if (sent < 4) begin
        drv_a(1'b1, rnd64(), sent == 3, 1'b0);
        if (m_rdy(ma, 2)) sent++;
      end else drv_a(1'b0, rnd64(), 1'b0, 1'b0);
    end
    $display("test_simul: done");
  endtask

  task automatic test_len_err();
    int sent = 0, fr = 0;
    int bpf[2] = '{0, 0};
    drain_a();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      checks++;
      if (obs_a() !== exp_a()) begin
        errors++; $display("FAIL len c=%0d got=%h exp=%h", c, obs_a(), exp_a());
      end
      if (fs_a) fr++;
      if (net_vld_a && fr >= 1 && fr <= 2) begin
        bpf[fr-1]++;
        if (fr == 1 && bpf[0] == 2) begin
          checks++;
          if (el_a !== 1'b1) begin errors++; $display("FAIL len_early got=%b exp=1", el_a); end
        end
      end
      if (sent < 8) begin
        drv_a(1'b1, rnd64(), (sent < 4) && (sent == 1), 1'b0);
        if (m_rdy(ma, 2)) sent++;
      end else drv_a(1'b0, rnd64(), 1'b0, 1'b0);
    end
    checks++;
    if (bpf[0] !== 4 || bpf[1] !== 4) begin
      errors++; $display("FAIL len_beats got=%0d,%0d exp=4,4", bpf[0], bpf[1]);
    end
    checks++;
    if (el_a !== 1'b1) begin errors++; $display("FAIL len_sticky got=%b exp=1", el_a); end
    $display("test_len_err: frames=%0d beats=%0d,%0d", fr, bpf[0], bpf[1]);
  endtask

  task automatic test_spur();
    int sent = 0;
    bit exp_fd;
    logic [1:0] exp_inf;
    @(negedge clk);
    drv_b(1'b0, rnd64(), 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (es_b !== 1'b1 || inf_b !== 2'd0) begin
      errors++; $display("FAIL spur got es=%b inf=%0d exp es=1 inf=0", es_b, inf_b);
    end
    drv_b(1'b0, rnd64(), 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (obs_b() !== exp_b()) begin
        errors++; $display("FAIL spur_frame c=%0d got=%h exp=%h", c, obs_b(), exp_b());
      end
      if (sent < 4) begin
        drv_b(1'b1, rnd64(), sent == 3, 1'b0);
        if (m_rdy(mb, 2)) sent++;
      end else drv_b(1'b0, rnd64(), 1'b0, 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drv_b(1'b0, rnd64(), 1'b0, 1'b1);
      @(negedge clk);
      exp_fd = (k == 2);
      exp_inf = (k == 2) ? 2'd0 : 2'd1;
      checks++;
      if (fd_b !== exp_fd || inf_b !== exp_inf) begin
        errors++; $display("FAIL opf k=%0d got fd=%b inf=%0d exp fd=%b inf=%0d", k, fd_b, inf_b, exp_fd, exp_inf);
      end
      drv_b(1'b0, rnd64(), 1'b0, 1'b0);
    end
    $display("test_spur: done");
  endtask

  task automatic test_reset_mid();
    int sent = 0;
    drain_a();
    for (int c = 0; c < 8 && sent < 3; c++) begin
      @(negedge clk);
      drv_a(1'b1, rnd64(), 1'b0, 1'b0);
      if (m_rdy(ma, 2)) sent++;
    end
    @(negedge clk);
    checks++;
    if (obs_a() !== exp_a()) begin errors++; $display("FAIL rmid_pre got=%h exp=%h", obs_a(), exp_a()); end
    drv_a(1'b0, rnd64(), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (net_vld_a !== 1'b0 || inf_a !== 2'd0 || ifa.s_rdy !== 1'b1) begin
      errors++; $display("FAIL rmid_async got vld=%b inf=%0d rdy=%b exp vld=0 inf=0 rdy=1", net_vld_a, inf_a, ifa.s_rdy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sent = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (obs_a() !== exp_a()) begin
        errors++; $display("FAIL rmid c=%0d got=%h exp=%h", c, obs_a(), exp_a());
      end
      if (c == 1) begin
        checks++;
        if (fs_a !== 1'b1 || net_vld_a !== 1'b1) begin
          errors++; $display("FAIL rmid_start got fs=%b vld=%b exp fs=1 vld=1", fs_a, net_vld_a);
        end
      end
      if (sent < 4) begin
        drv_a(1'b1, rnd64(), sent == 3, 1'b0);
        if (m_rdy(ma, 2)) sent++;
      end else drv_a(1'b0, rnd64(), 1'b0, 1'b0);
    end
    checks++;
    if (el_a !== 1'b0) begin errors++; $display("FAIL rmid_err_len got=%b exp=0", el_a); end
    $display("test_reset_mid: done");
  endtask

  task automatic test_random();
    int frames = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      checks++;
      if (obs_a() !== exp_a()) begin
        errors++; $display("FAIL rand_a c=%0d got=%h exp=%h", c, obs_a(), exp_a());
      end
      checks++;
      if (obs_b() !== exp_b()) begin
        errors++; $display("FAIL rand_b c=%0d got=%h exp=%h", c, obs_b(), exp_b());
      end
      if (fs_a) begin
        frames++;
        if (frames % 10 == 0) $display("test_random: dut_a frame %0d at cycle %0d inflight=%0d", frames, c, inf_a);
      end
      drv_a($urandom_range(0, 3) != 0, rnd64(), (ma.pos == 3) ^ ($urandom_range(0, 19) == 0),
            $urandom_range(0, 5) == 0);
      drv_b($urandom_range(0, 3) != 0, rnd64(), (mb.pos == 3) ^ ($urandom_range(0, 19) == 0),
            $urandom_range(0, 2) == 0);
    end
    $display("test_random: dut_a frames=%0d", frames);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_inflight_cap();
    test_simul();
    test_len_err();
    test_spur();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/iq_frame_sched.md
# iq_frame_sched

Admission controller and frame sequencer at the front of the `tw_vgg_2iq` datapath. It accepts IQ sample pairs from an upstream valid/ready source and drives the network's `vld_in`/`data_in`, with exact frame boundaries of 2^L2_IMG samples. It caps the number of frames in flight inside the network by counting classification results on the network's `vld_out`. It also enforces a minimum idle gap between frames so the windowers and serial stages flush cleanly.

## Interface
Parameters:
- `BW`, 16, sample word width.
- `L2_IMG`, 10, log2 samples per frame; `FRAME_BEATS = 2^(L2_IMG-1)` beats, two IQ samples per beat.
- `MAX_INFLIGHT`, 2, max frames admitted but not yet fully output (≥1).
- `GAP_CYC`, 16, idle cycles forced after each frame's last beat (0 allowed).
- `OUT_PER_FRAME`, 1, network `vld_out` pulses per frame.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_vld` in 1: upstream beat valid.
- `s_rdy` out 1: upstream ready; a beat transfers when `s_vld & s_rdy`.
- `s_data` in [3:0][BW-1:0]: two IQ samples, same packing as network `data_in`.
- `s_last` in 1: upstream end-of-frame marker, checked only.
- `net_vld` out 1: drives network `vld_in`.
- `net_data` out [3:0][BW-1:0]: drives network `data_in`.
- `net_out_vld` in 1: network `vld_out`.
- `frame_start` out 1: one-cycle pulse, registered with the first beat of a frame.
- `frame_done` out 1: one-cycle pulse when a frame's final result is counted.
- `inflight` out $clog2(MAX_INFLIGHT+1): frames currently in flight.
- `err_len` out 1: sticky `s_last` misalignment flag.
- `err_spur` out 1: sticky flag for `net_out_vld` received with `inflight==0`.

## Operation
- The FSM has three states: IDLE, STREAM, GAP.
- IDLE: `s_rdy = (inflight < MAX_INFLIGHT)`. An accepted beat counts as beat 0 and moves the FSM to STREAM. It also asserts `frame_start` and increments `inflight`.
- STREAM: `s_rdy = 1`. Each accepted beat increments `beat_cnt`. When beat `FRAME_BEATS-1` is accepted, the FSM goes to GAP if `GAP_CYC>0`, otherwise to IDLE. Stalls (`s_vld=0`) are allowed mid-frame and the FSM holds.
- GAP: `s_rdy = 0`. `gap_cnt` counts `GAP_CYC` cycles, then the FSM goes to IDLE.
- `s_rdy` is combinational from registered state and `inflight` only. It never depends on `s_vld`.
- Datapath: on every accepted beat, `net_data <= s_data` and `net_vld <= 1`. Otherwise `net_vld <= 0` and `net_data` holds.
- Frame length is authoritative. `s_last` on a non-final beat sets `err_len`, and the frame continues. A final beat without `s_last` also sets `err_len`. `s_last` is ignored in IDLE/GAP.
- Output tracking: `out_cnt` counts `net_out_vld` pulses modulo `OUT_PER_FRAME`.
  - On wrap, `inflight` decrements and `frame_done` pulses the next cycle.
  - `net_out_vld` while `inflight==0` sets `err_spur` and changes no counters.
- Simultaneous frame admit and frame completion in one cycle leave `inflight` unchanged, and both pulses fire.
- `inflight` never exceeds `MAX_INFLIGHT`, because admission is blocked at that value.
- Error flags clear only on reset.

## Timing
- Reset (async assert, sync deassert externally): the FSM enters IDLE.
- Reset values:
  - Counters `beat_cnt`, `gap_cnt`, `out_cnt`, and `inflight` are 0.
  - `net_vld`, `frame_start`, `frame_done`, `err_len`, and `err_spur` are 0.
  - `net_data` is 0.
  - `s_rdy` is 1, since `inflight=0`.
- Reset mid-frame drops the partial frame immediately; `net_vld` goes low asynchronously.
- Latency: an accepted `s_data` appears on `net_data`/`net_vld` 1 cycle later.
- `frame_start` is coincident with the first `net_vld` of the frame.
- `frame_done` is 1 cycle after the counting `net_out_vld`.
- Back-to-back frames: the next frame's first beat can be accepted at the earliest `GAP_CYC+1` cycles after the final beat's acceptance cycle, subject to `inflight`.
- Peak throughput is 1 beat/cycle during STREAM.

## Test plan
- L2_IMG=3, GAP_CYC=2, continuous `s_vld`, `s_last` on beat 3:
  - Expect 4 consecutive `net_vld` beats with data matching 1 cycle late, and `frame_start` on beat 0.
  - Expect `s_rdy` low for exactly 2 cycles after beat 3; `err_len` stays 0.
- MAX_INFLIGHT=2 with no `net_out_vld`:
  - After 2 frames, `inflight=2` and `s_rdy` stays 0 indefinitely.
  - One `net_out_vld` → `frame_done` pulse, `inflight=1`, `s_rdy=1` the next cycle.
- Admit a frame's first beat in the same cycle as `net_out_vld` with `inflight=1`:
  - `inflight` stays 1, and both `frame_start` and `frame_done` pulse.
- `s_last` on beat 1 of 4, and a second frame with no `s_last`:
  - `err_len` is set after beat 1 and stays set; both frames still emit exactly 4 beats.
- `net_out_vld` with `inflight=0`:
  - `err_spur=1` and `inflight` stays 0.
  - With OUT_PER_FRAME=3, `frame_done` fires only on the 3rd pulse.
- Drop `rst_n` at beat 2 mid-frame:
  - `net_vld`/`inflight` are 0 immediately and the FSM is in IDLE.
  - The next accepted beat is treated as beat 0 with a `frame_start` pulse.
